fetch_stage: RTL and testbench

Parametrised instruction-fetch stage for the RV32IM pipeline. It combines PC generation, an instruction-memory request/grant/response handshake, and the IF/ID output register. It also supports decode-side stall, redirect (branch/jump) with in-flight response kill, and one pending-response buffer. It sits between the instruction memory port and the decode stage and drives the IF/ID bundle consumed by decode.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_pc_reg.sv | 36 +++
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
//
// Purpose : FSM state encoding, NOP encoding, default XLEN and PC increment
//           shared by fetch_stage and fetch_pc_reg.
// Ports   : none (package).
package fetch_pkg;

   localparam int          XLEN_DEFAULT = 32;
   localparam int          PC_INCR      = 4;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   // HALT is only reachable when FETCH_MISALIGN_EN is defined.
   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      FULL = 2'd2,
      HALT = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register for the fetch stage
//
// Purpose : holds the next fetch address; reset vector, +4 on grant,
//           redirect load (load wins over increment).
// Ports   : clk, rst_n (async, active-low)
//           inc      - advance PC by 4 (wraps modulo 2^XLEN)
//           load     - load load_pc
//           load_pc  - redirect target
//           pc       - current PC
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc,
   input  logic            load,
   input  logic [XLEN-1:0] load_pc,
   output logic [XLEN-1:0] pc
);

   localparam logic [XLEN-1:0] INCR = XLEN'(PC_INCR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_VECTOR;
      end else if (load) begin
         pc <= load_pc;
      end else if (inc) begin
         pc <= pc + INCR;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32IM instruction-fetch stage with IF/ID output register
//
// Purpose : PC generation, single-outstanding imem request/grant/response
//           handshake, one pending-response buffer, redirect with in-flight
//           response kill, IF/ID bundle register.
// Config  : FETCH_MISALIGN_EN - misaligned redirect raises ID_EXC and halts
//           fetch until the next redirect; when undefined the redirect target
//           is forced word-aligned and ID_EXC is tied 0.
// Ports   : CLK, RESET (async, active-low)
//           IMEM_REQ/IMEM_ADDR/IMEM_GNT      - request channel
//           IMEM_RVALID/IMEM_RDATA          - response channel
//           REDIRECT/REDIRECT_PC            - branch/jump restart
//           ID_STALL                        - decode back-pressure
//           ID_VALID/ID_INSTR/ID_PC/ID_PC_PLUS_4/ID_EXC - IF/ID bundle
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            CLK,
   input  logic            RESET,
   output logic            IMEM_REQ,
   output logic [XLEN-1:0] IMEM_ADDR,
   input  logic            IMEM_GNT,
   input  logic            IMEM_RVALID,
   input  logic [31:0]     IMEM_RDATA,
   input  logic            REDIRECT,
   input  logic [XLEN-1:0] REDIRECT_PC,
   input  logic            ID_STALL,
   output logic            ID_VALID,
   output logic [31:0]     ID_INSTR,
   output logic [XLEN-1:0] ID_PC,
   output logic [XLEN-1:0] ID_PC_PLUS_4,
   output logic            ID_EXC
);

   localparam logic [XLEN-1:0] INCR = XLEN'(PC_INCR);

   fetch_state_e    state, state_nxt;
   logic            kill, kill_nxt;
   logic [XLEN-1:0] pc, inflight_pc, pend_pc, redirect_tgt;
   logic [31:0]     pend_instr;
   logic            grant, out_free, misalign;
   logic            load_resp, load_pend, pend_store;

   // Request depends on registered state only, never on RVALID or ID_STALL.
   assign IMEM_REQ  = (state == REQ) && !kill;
   assign IMEM_ADDR = pc;
   assign grant     = IMEM_REQ && IMEM_GNT;
   assign out_free  = !ID_VALID || !ID_STALL;

`ifdef FETCH_MISALIGN_EN
   assign redirect_tgt = REDIRECT_PC;
   assign misalign     = REDIRECT && (REDIRECT_PC[1:0] != 2'b00);
`else
   assign redirect_tgt = REDIRECT_PC & ~XLEN'(3);
   assign misalign     = 1'b0;
`endif

   assign load_resp  = !REDIRECT && (state == WAIT) && IMEM_RVALID && out_free;
   assign pend_store = !REDIRECT && (state == WAIT) && IMEM_RVALID && !out_free;
   assign load_pend  = !REDIRECT && (state == FULL) && !ID_STALL;

   fetch_pc_reg #(
      .XLEN        (XLEN),
      .RESET_VECTOR(RESET_VECTOR)
   ) u_pc (
      .clk    (CLK),
      .rst_n  (RESET),
      .inc    (grant && !REDIRECT),
      .load   (REDIRECT),
      .load_pc(redirect_tgt),
      .pc     (pc)
   );

   always_comb begin
      state_nxt = state;
      kill_nxt  = kill;
      case (state)
         REQ:     if (grant) state_nxt = WAIT;
         WAIT:    if (IMEM_RVALID) state_nxt = out_free ? REQ : FULL;
         FULL:    if (!ID_STALL) state_nxt = REQ;
         default: state_nxt = state;
      endcase
      // A response arriving in the redirect cycle itself retires the
      // outstanding request, so it must not leave KILL armed.
      if (kill && IMEM_RVALID) kill_nxt = 1'b0;
      if (REDIRECT) begin
         state_nxt = misalign ? HALT : REQ;
         kill_nxt  = ((state == WAIT || kill) && !IMEM_RVALID) || grant;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state        <= REQ;
         kill         <= 1'b0;
         inflight_pc  <= '0;
         pend_pc      <= '0;
         pend_instr   <= NOP_INSTR;
         ID_VALID     <= 1'b0;
         ID_INSTR     <= NOP_INSTR;
         ID_PC        <= '0;
         ID_PC_PLUS_4 <= '0;
      end else begin
         state <= state_nxt;
         kill  <= kill_nxt;
         if (grant) inflight_pc <= pc;
         if (pend_store) begin
            pend_instr <= IMEM_RDATA;
            pend_pc    <= inflight_pc;
         end
         if (REDIRECT) begin
            // Misaligned target turns into an exception bundle instead of a fetch.
            ID_VALID <= misalign;
            if (misalign) begin
               ID_INSTR     <= NOP_INSTR;
               ID_PC        <= REDIRECT_PC;
               ID_PC_PLUS_4 <= REDIRECT_PC + INCR;
            end
         end else if (load_resp) begin
            ID_VALID     <= 1'b1;
            ID_INSTR     <= IMEM_RDATA;
            ID_PC        <= inflight_pc;
            ID_PC_PLUS_4 <= inflight_pc + INCR;
         end else if (load_pend) begin
            ID_VALID     <= 1'b1;
            ID_INSTR     <= pend_instr;
            ID_PC        <= pend_pc;
            ID_PC_PLUS_4 <= pend_pc + INCR;
         end else if (ID_VALID && !ID_STALL) begin
            ID_VALID <= 1'b0;
         end
      end
   end

`ifdef FETCH_MISALIGN_EN
   logic exc_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         exc_q <= 1'b0;
      end else if (REDIRECT) begin
         exc_q <= misalign;
      end else if (load_resp || load_pend) begin
         exc_q <= 1'b0;
      end
   end

   assign ID_EXC = exc_q;
`else
   assign ID_EXC = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
//
// Purpose : cycle table after reset, scoreboarded random traffic with
//           redirects/stalls/variable latency, reset abort and misaligned
//           redirect sequences.
// Ports   : none (top-level bench).
module tb_fetch_stage;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_GNT;
   logic        IMEM_RVALID;
   logic [31:0] IMEM_RDATA;
   logic        REDIRECT;
   logic [31:0] REDIRECT_PC;
   logic        ID_STALL;
   logic        ID_VALID;
   logic [31:0] ID_INSTR;
   logic [31:0] ID_PC;
   logic [31:0] ID_PC_PLUS_4;
   logic        ID_EXC;

   fetch_stage #(
      .XLEN        (32),
      .RESET_VECTOR(32'h0000_0100)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .IMEM_REQ    (IMEM_REQ),
      .IMEM_ADDR   (IMEM_ADDR),
      .IMEM_GNT    (IMEM_GNT),
      .IMEM_RVALID (IMEM_RVALID),
      .IMEM_RDATA  (IMEM_RDATA),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC),
      .ID_STALL    (ID_STALL),
      .ID_VALID    (ID_VALID),
      .ID_INSTR    (ID_INSTR),
      .ID_PC       (ID_PC),
      .ID_PC_PLUS_4(ID_PC_PLUS_4),
      .ID_EXC      (ID_EXC)
   );

   always #5 CLK = ~CLK;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] I0   = 32'h0050_0093;
   localparam logic [31:0] I1   = 32'h00A0_0113;
   localparam logic [31:0] I2   = 32'h00F0_0193;
   localparam logic [31:0] I3   = 32'h0140_0213;
   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

   typedef struct {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        stall;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   localparam int NV = 17;
   vec_t        tbl [NV];
   exp_t        sb [$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_cons  = 0;
   int          cnt     = 0;
   logic [31:0] exp_pc;
   logic [31:0] resp_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   function automatic vec_t row(input logic g, input logic rv, input logic [31:0] rd,
                                input logic rdr, input logic [31:0] rpc, input logic st,
                                input logic ereq, input logic [31:0] ea, input logic ev,
                                input logic [31:0] epc, input logic [31:0] ei);
      vec_t v;
      v.gnt = g; v.rvalid = rv; v.rdata = rd; v.redir = rdr; v.rpc = rpc; v.stall = st;
      v.e_req = ereq; v.e_addr = ea; v.e_valid = ev; v.e_pc = epc; v.e_instr = ei;
      return v;
   endfunction

   function automatic logic [31:0] memdata(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   // One cycle of the memory model + scoreboard; inputs change on negedge.
   task automatic tick(input logic stall, input logic redir, input logic [31:0] tgt,
                       input logic gnt_ok, input logic spur);
      exp_t e;
      @(negedge CLK);
      IMEM_RVALID = 1'b0;
      IMEM_RDATA  = JUNK;
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = memdata(resp_addr);
         end
      end else if (spur) begin
         IMEM_RVALID = 1'b1;
      end
      IMEM_GNT    = IMEM_REQ && gnt_ok;
      ID_STALL    = stall;
      REDIRECT    = redir;
      REDIRECT_PC = tgt;
      if (IMEM_GNT) begin
         check("grant_addr", IMEM_ADDR, exp_pc);
         check("one_outstanding", 32'(cnt), 32'd0);
         sb.push_back('{pc: exp_pc, instr: memdata(exp_pc)});
         exp_pc    = exp_pc + 32'd4;
         cnt       = $urandom_range(1, 3);
         resp_addr = IMEM_ADDR;
      end
      if (ID_VALID && !stall && !redir) begin
         n_cons++;
         check("sb_underflow", 32'(sb.size() == 0), 32'd0);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_pc", ID_PC, e.pc);
            check("sb_instr", ID_INSTR, e.instr);
            check("sb_pc_plus_4", ID_PC_PLUS_4, e.pc + 32'd4);
            check("sb_exc", 32'(ID_EXC), 32'd0);
         end
      end
      if (redir) begin
         sb.delete();
         exp_pc = tgt;
      end
   endtask

   initial begin
      logic [31:0] tgt;
      RESET = 1'b0; IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0;
      REDIRECT = 1'b0; REDIRECT_PC = '0; ID_STALL = 1'b0;

      tbl[0]  = row(1, 0, 0,    0, 0,      0, 1, 32'h100, 0, 0,      0);
      tbl[1]  = row(0, 1, I0,   0, 0,      0, 0, 32'h104, 0, 0,      0);
      tbl[2]  = row(1, 0, 0,    0, 0,      0, 1, 32'h104, 1, 32'h100, I0);
      tbl[3]  = row(0, 1, I1,   0, 0,      1, 0, 32'h108, 0, 0,      0);
      tbl[4]  = row(1, 0, 0,    0, 0,      1, 1, 32'h108, 1, 32'h104, I1);
      tbl[5]  = row(0, 1, I2,   0, 0,      1, 0, 32'h10C, 1, 32'h104, I1);
      tbl[6]  = row(0, 0, 0,    0, 0,      1, 0, 32'h10C, 1, 32'h104, I1);
      tbl[7]  = row(0, 0, 0,    0, 0,      0, 0, 32'h10C, 1, 32'h104, I1);
      tbl[8]  = row(0, 0, 0,    1, 32'h200, 1, 1, 32'h10C, 1, 32'h108, I2);
      tbl[9]  = row(1, 0, 0,    0, 0,      0, 1, 32'h200, 0, 0,      0);
      tbl[10] = row(0, 0, 0,    1, 32'h300, 0, 0, 32'h204, 0, 0,      0);
      tbl[11] = row(0, 0, 0,    0, 0,      0, 0, 32'h300, 0, 0,      0);
      tbl[12] = row(0, 1, JUNK, 0, 0,      0, 0, 32'h300, 0, 0,      0);
      tbl[13] = row(1, 0, 0,    0, 0,      0, 1, 32'h300, 0, 0,      0);
      tbl[14] = row(0, 1, I3,   0, 0,      0, 0, 32'h304, 0, 0,      0);
      tbl[15] = row(0, 0, 0,    0, 0,      0, 1, 32'h304, 1, 32'h300, I3);
      tbl[16] = row(0, 0, 0,    0, 0,      0, 1, 32'h304, 0, 0,      0);

      repeat (2) @(negedge CLK);
      check("rst_req", 32'(IMEM_REQ), 32'd1);
      check("rst_addr", IMEM_ADDR, 32'h100);
      check("rst_valid", 32'(ID_VALID), 32'd0);
      check("rst_instr", ID_INSTR, NOP);
      check("rst_pc", ID_PC, 32'd0);
      check("rst_pc4", ID_PC_PLUS_4, 32'd0);
      check("rst_exc", 32'(ID_EXC), 32'd0);
      RESET = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge CLK);
         check($sformatf("v%0d_req", i), 32'(IMEM_REQ), 32'(tbl[i].e_req));
         check($sformatf("v%0d_addr", i), IMEM_ADDR, tbl[i].e_addr);
         check($sformatf("v%0d_valid", i), 32'(ID_VALID), 32'(tbl[i].e_valid));
         if (tbl[i].e_valid) begin
            check($sformatf("v%0d_pc", i), ID_PC, tbl[i].e_pc);
            check($sformatf("v%0d_instr", i), ID_INSTR, tbl[i].e_instr);
            check($sformatf("v%0d_pc4", i), ID_PC_PLUS_4, tbl[i].e_pc + 32'd4);
         end
         IMEM_GNT    = tbl[i].gnt;
         IMEM_RVALID = tbl[i].rvalid;
         IMEM_RDATA  = tbl[i].rdata;
         REDIRECT    = tbl[i].redir;
         REDIRECT_PC = tbl[i].rpc;
         ID_STALL    = tbl[i].stall;
      end

      // Random traffic; first redirect lands just below the wrap point.
      exp_pc = 32'h304;
      tick(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
      for (int c = 0; c < 3000; c++) begin
         tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                            : 32'h0000_2000 + ($urandom_range(0, 63) << 2);
         tick($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0, tgt,
              $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      end
      check("throughput", 32'(n_cons > 300), 32'd1);

      // Reset in the middle of traffic, response in the first cycle after release.
      @(negedge CLK);
      RESET = 1'b0; IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; REDIRECT = 1'b0; ID_STALL = 1'b0;
      cnt = 0;
      sb.delete();
      @(negedge CLK);
      check("mid_rst_valid", 32'(ID_VALID), 32'd0);
      check("mid_rst_addr", IMEM_ADDR, 32'h100);
      RESET = 1'b1;
      IMEM_RVALID = 1'b1;
      IMEM_RDATA  = JUNK;
      @(negedge CLK);
      check("post_rst_valid", 32'(ID_VALID), 32'd0);
      check("post_rst_req", 32'(IMEM_REQ), 32'd1);
      check("post_rst_addr", IMEM_ADDR, 32'h100);
      IMEM_RVALID = 1'b0;
      REDIRECT    = 1'b1;
      REDIRECT_PC = 32'h202;
      @(negedge CLK);
      REDIRECT = 1'b0;
`ifdef FETCH_MISALIGN_EN
      check("mis_req", 32'(IMEM_REQ), 32'd0);
      check("mis_valid", 32'(ID_VALID), 32'd1);
      check("mis_exc", 32'(ID_EXC), 32'd1);
      check("mis_pc", ID_PC, 32'h202);
      check("mis_instr", ID_INSTR, NOP);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check($sformatf("halt%0d_req", k), 32'(IMEM_REQ), 32'd0);
      end
      REDIRECT    = 1'b1;
      REDIRECT_PC = 32'h300;
      @(negedge CLK);
      REDIRECT = 1'b0;
      check("resume_req", 32'(IMEM_REQ), 32'd1);
      check("resume_addr", IMEM_ADDR, 32'h300);
      check("resume_exc", 32'(ID_EXC), 32'd0);
`else
      check("mis_req", 32'(IMEM_REQ), 32'd1);
      check("mis_addr", IMEM_ADDR, 32'h200);
      check("mis_valid", 32'(ID_VALID), 32'd0);
      check("mis_exc", 32'(ID_EXC), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
